// File: rtl/pistorm_pkg.sv
// Shared definitions for the Pi-facing GPIO register file.
// Register selects, STATUS bit positions and request FSM states.
package pistorm_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // STATUS read bits
    localparam int ST_BUSY      = 0;
    localparam int ST_RESET_OUT = 1;
    localparam int ST_OVERRUN   = 2;

    // STATUS write bits
    localparam int ST_WR_RESET_OUT = 1;
    localparam int ST_WR_CLR_OVR   = 2;

    // ADDR_HI write bits
    localparam int HI_SZ = 8;
    localparam int HI_RW = 9;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_BUSY = 1'b1
    } req_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Multi-flop synchronizer for an asynchronous strobe plus a rising-edge pulse.
// Ports: clk, rst (sync, active-high), strobe (async in), rise (1-cycle pulse out).
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pi_gpio_regs.sv
// Pi-side register file: latches address/data/op from Pi writes and issues one
// 68K bus request at a time to the bus cycle sequencer, capturing read data back.
// Ports: PI_CLK/RST; Pi bus PI_A, PI_RD, PI_WR, PI_D_IN, PI_D_OUT, PI_D_OE,
// PI_TXN_IN_PROGRESS; sequencer BUS_REQ/ADDR/SZ/RW/DOUT, BUS_DONE/DIN/ABORT;
// IPL (interrupt level in), RESET_OUT (hold Amiga in reset).
module pi_gpio_regs
    import pistorm_pkg::*;
#(
    parameter int   SYNC_STAGES    = 2,
    parameter logic RESET_OUT_INIT = 1'b1
) (
    input  logic        PI_CLK,
    input  logic        RST,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    output logic        PI_TXN_IN_PROGRESS,
    output logic        BUS_REQ,
    output logic [23:0] BUS_ADDR,
    output logic        BUS_SZ,
    output logic        BUS_RW,
    output logic [15:0] BUS_DOUT,
    input  logic        BUS_DONE,
    input  logic [15:0] BUS_DIN,
    input  logic        BUS_ABORT,
    input  logic [2:0]  IPL,
    output logic        RESET_OUT
);

    req_state_t  state_q, state_d;
    logic        start_q;
    logic [1:0]  a_q;
    logic [15:0] d_q;
    logic [23:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        sz_q;
    logic        rw_q;
    logic        reset_out_q;
    logic        overrun_q;
    logic        busy;
    logic        hold;
    logic        wr_rise;
    logic        unused_rd_rise;
    logic        wr_data, wr_lo, wr_hi, wr_stat;
    logic        hi_ok, hi_drop;

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk    (PI_CLK),
        .rst    (RST),
        .strobe (PI_WR),
        .rise   (wr_rise)
    );

    // Reads are served combinationally; the synced edge exists only for symmetry.
    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk    (PI_CLK),
        .rst    (RST),
        .strobe (PI_RD),
        .rise   (unused_rd_rise)
    );

    assign busy = (state_q == REQ_BUSY);
    // start_q covers the cycle between ADDR_HI commit and BUSY entry.
    assign hold = busy | start_q;

    assign wr_data = wr_rise & (a_q == REG_DATA);
    assign wr_lo   = wr_rise & (a_q == REG_ADDR_LO);
    assign wr_hi   = wr_rise & (a_q == REG_ADDR_HI);
    assign wr_stat = wr_rise & (a_q == REG_STATUS);
    assign hi_ok   = wr_hi & ~hold;
    assign hi_drop = wr_hi & hold;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REQ_IDLE: if (start_q) state_d = REQ_BUSY;
            REQ_BUSY: if (BUS_ABORT | BUS_DONE) state_d = REQ_IDLE;
            default:  state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge PI_CLK) begin
        if (RST) begin
            state_q     <= REQ_IDLE;
            start_q     <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sz_q        <= 1'b0;
            rw_q        <= 1'b1;
            reset_out_q <= RESET_OUT_INIT;
            overrun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= hi_ok;
            // sampled alongside the last WR sync flop
            a_q     <= PI_A;
            d_q     <= PI_D_IN;

            if (wr_data & ~hold) wdata_q <= d_q;
            if (wr_lo & ~hold) addr_q[15:0] <= d_q;
            if (hi_ok) begin
                addr_q[23:16] <= d_q[7:0];
                sz_q          <= d_q[HI_SZ];
                rw_q          <= d_q[HI_RW];
            end

            if (busy & BUS_DONE & ~BUS_ABORT & rw_q) rdata_q <= BUS_DIN;

            if (wr_stat) begin
                reset_out_q <= d_q[ST_WR_RESET_OUT];
                if (d_q[ST_WR_CLR_OVR]) overrun_q <= 1'b0;
            end else if (hi_drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        PI_D_OUT = '0;
        unique case (1'b1)
            (PI_A == REG_DATA):    PI_D_OUT = rdata_q;
            (PI_A == REG_ADDR_LO): PI_D_OUT = addr_q[15:0];
            (PI_A == REG_ADDR_HI): PI_D_OUT = {6'd0, rw_q, sz_q, addr_q[23:16]};
            (PI_A == REG_STATUS):  PI_D_OUT = {IPL, 10'd0, overrun_q, reset_out_q, busy};
            default:               PI_D_OUT = '0;
        endcase
    end

    assign PI_D_OE            = PI_RD;
    assign PI_TXN_IN_PROGRESS = busy;
    assign BUS_REQ            = busy;
    assign BUS_ADDR           = addr_q;
    assign BUS_SZ             = sz_q;
    assign BUS_RW             = rw_q;
    assign BUS_DOUT           = wdata_q;
    assign RESET_OUT          = reset_out_q;

endmodule

// File: tb/tb_pi_gpio_regs.sv
// Self-checking bench for pi_gpio_regs.
// Directed scenarios plus a randomized run against a register-level model.
`timescale 1ns/1ps
module tb_pi_gpio_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pi_a = '0;
    logic        pi_rd = 1'b0;
    logic        pi_wr = 1'b0;
    logic [15:0] pi_d_in = '0;
    logic [15:0] pi_d_out;
    logic        pi_d_oe;
    logic        txn;
    logic        bus_req;
    logic [23:0] bus_addr;
    logic        bus_sz;
    logic        bus_rw;
    logic [15:0] bus_dout;
    logic        bus_done = 1'b0;
    logic [15:0] bus_din = '0;
    logic        bus_abort = 1'b0;
    logic [2:0]  ipl = '0;
    logic        reset_out;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [23:0] m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic        m_sz, m_rw, m_ro, m_ov, m_busy;

    pi_gpio_regs dut (
        .PI_CLK             (clk),
        .RST                (rst),
        .PI_A               (pi_a),
        .PI_RD              (pi_rd),
        .PI_WR              (pi_wr),
        .PI_D_IN            (pi_d_in),
        .PI_D_OUT           (pi_d_out),
        .PI_D_OE            (pi_d_oe),
        .PI_TXN_IN_PROGRESS (txn),
        .BUS_REQ            (bus_req),
        .BUS_ADDR           (bus_addr),
        .BUS_SZ             (bus_sz),
        .BUS_RW             (bus_rw),
        .BUS_DOUT           (bus_dout),
        .BUS_DONE           (bus_done),
        .BUS_DIN            (bus_din),
        .BUS_ABORT          (bus_abort),
        .IPL                (ipl),
        .RESET_OUT          (reset_out)
    );

    always #2.5 clk = ~clk;

    task automatic model_reset();
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_sz = 0; m_rw = 1; m_ro = 1; m_ov = 0; m_busy = 0;
    endtask

    task automatic model_write(input logic [1:0] a, input logic [15:0] d);
        if (a == 2'd3) begin
            m_ro = d[1];
            if (d[2]) m_ov = 0;
        end else if (m_busy) begin
            if (a == 2'd2) m_ov = 1;
        end else if (a == 2'd0) begin
            m_wdata = d;
        end else if (a == 2'd1) begin
            m_addr[15:0] = d;
        end else begin
            m_addr[23:16] = d[7:0];
            m_sz = d[8];
            m_rw = d[9];
            m_busy = 1;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_rdata;
            2'd1:    return m_addr[15:0];
            2'd2:    return {6'd0, m_rw, m_sz, m_addr[23:16]};
            default: return {ipl, 10'd0, m_ov, m_ro, m_busy};
        endcase
    endfunction

    task automatic start_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        pi_a = a; pi_d_in = d; pi_wr = 1'b1;
    endtask

    task automatic end_write();
        @(negedge clk);
        pi_wr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        start_write(a, d);
        repeat (4) @(posedge clk);
        end_write();
        model_write(a, d);
    endtask

    task automatic pi_read(input logic [1:0] a, output logic [15:0] v, output logic oe);
        @(negedge clk);
        pi_a = a; pi_rd = 1'b1;
        #1;
        v = pi_d_out; oe = pi_d_oe;
        pi_rd = 1'b0;
    endtask

    task automatic bus_pulse(input logic done, input logic abort, input logic [15:0] din);
        @(negedge clk);
        bus_done = done; bus_abort = abort; bus_din = din;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus_done = 1'b0; bus_abort = 1'b0;
        if (m_busy && abort) m_busy = 0;
        else if (m_busy && done) begin
            if (m_rw) m_rdata = din;
            m_busy = 0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] v; logic oe;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (reset_out !== 1'b1 || bus_req !== 1'b0 || txn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: reset_out=%b req=%b txn=%b want 1 0 0", reset_out, bus_req, txn);
        end
        pi_read(2'd3, v, oe);
        n_checks++;
        if (v !== 16'h0002 || oe !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: got %h oe=%b want 0002 oe=1", v, oe);
        end
        pi_read(2'd2, v, oe);
        n_checks++;
        if (v !== 16'h0200) begin
            n_fail++;
            $display("FAIL reset_addr_hi: got %h want 0200", v);
        end
        n_checks++;
        if (pi_d_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_idle: got %b want 0", pi_d_oe);
        end
    endtask

    task automatic test_word_read();
        logic [15:0] v; logic oe;
        int cyc;
        pi_write(2'd1, 16'h2344);
        start_write(2'd2, 16'h02DF);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (bus_req !== 1'b1 && cyc < 20);
        end_write();
        model_write(2'd2, 16'h02DF);
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL req_latency: got %0d cycles want 4", cyc);
        end
        n_checks++;
        if (bus_addr !== 24'hDF2344 || bus_rw !== 1'b1 || bus_sz !== 1'b0 || txn !== 1'b1) begin
            n_fail++;
            $display("FAIL word_req: addr=%h rw=%b sz=%b txn=%b want DF2344 1 0 1", bus_addr, bus_rw, bus_sz, txn);
        end
        bus_pulse(1'b1, 1'b0, 16'hBEEF);
        n_checks++;
        if (txn !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL word_done: txn=%b req=%b want 0 0", txn, bus_req);
        end
        pi_read(2'd0, v, oe);
        n_checks++;
        if (v !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL word_rdata: got %h want beef", v);
        end
    endtask

    task automatic test_byte_write();
        logic [15:0] v; logic oe;
        pi_write(2'd0, 16'h00A5);
        pi_write(2'd1, 16'h0001);
        pi_write(2'd2, 16'h0100);
        n_checks++;
        if (bus_req !== 1'b1 || bus_sz !== 1'b1 || bus_rw !== 1'b0 ||
            bus_addr !== 24'h000001 || bus_dout !== 16'h00A5) begin
            n_fail++;
            $display("FAIL byte_req: req=%b sz=%b rw=%b addr=%h dout=%h want 1 1 0 000001 00a5",
                     bus_req, bus_sz, bus_rw, bus_addr, bus_dout);
        end
        bus_pulse(1'b1, 1'b0, 16'hFFFF);
        pi_read(2'd0, v, oe);
        n_checks++;
        if (v !== 16'hBEEF || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_rdata: got %h req=%b want beef 0", v, bus_req);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] v; logic oe;
        pi_write(2'd1, 16'h1000);
        pi_write(2'd2, 16'h0312);
        pi_write(2'd2, 16'h0055);
        pi_write(2'd1, 16'h7777);
        n_checks++;
        if (bus_addr !== 24'h121000 || bus_req !== 1'b1 || bus_rw !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_addr: addr=%h req=%b rw=%b want 121000 1 1", bus_addr, bus_req, bus_rw);
        end
        pi_read(2'd3, v, oe);
        n_checks++;
        if (v !== 16'h0007) begin
            n_fail++;
            $display("FAIL ovr_set: status=%h want 0007", v);
        end
        pi_write(2'd3, 16'h0004);
        pi_read(2'd3, v, oe);
        n_checks++;
        if (v !== 16'h0001 || reset_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: status=%h rst_out=%b want 0001 0", v, reset_out);
        end
    endtask

    task automatic test_abort();
        logic [15:0] v; logic oe;
        bus_pulse(1'b1, 1'b1, 16'h1234);
        pi_read(2'd0, v, oe);
        n_checks++;
        if (v !== 16'hBEEF || bus_req !== 1'b0 || txn !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: rdata=%h req=%b txn=%b want beef 0 0", v, bus_req, txn);
        end
    endtask

    task automatic test_status_ipl();
        logic [15:0] v; logic oe;
        int cyc;
        start_write(2'd3, 16'h0002);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (reset_out !== 1'b1 && cyc < 20);
        end_write();
        model_write(2'd3, 16'h0002);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL status_latency: got %0d cycles want 3", cyc);
        end
        ipl = 3'd5;
        pi_read(2'd3, v, oe);
        n_checks++;
        if (v !== 16'hA002) begin
            n_fail++;
            $display("FAIL status_ipl: got %h want a002", v);
        end
        ipl = 3'd0;
    endtask

    task automatic test_collision();
        logic [15:0] v; logic oe;
        pi_write(2'd1, 16'h0100);
        pi_write(2'd2, 16'h0233);
        @(negedge clk);
        pi_a = 2'd2; pi_d_in = 16'h0077; pi_wr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus_done = 1'b1; bus_din = 16'h5A5A;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus_done = 1'b0;
        pi_wr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        m_rdata = 16'h5A5A; m_busy = 0; m_ov = 1;
        n_checks++;
        if (bus_req !== 1'b0 || bus_addr !== 24'h330100) begin
            n_fail++;
            $display("FAIL coll_state: req=%b addr=%h want 0 330100", bus_req, bus_addr);
        end
        pi_read(2'd3, v, oe);
        n_checks++;
        if (v !== 16'h0006) begin
            n_fail++;
            $display("FAIL coll_status: got %h want 0006", v);
        end
        pi_read(2'd0, v, oe);
        n_checks++;
        if (v !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL coll_rdata: got %h want 5a5a", v);
        end
    endtask

    task automatic test_rst_mid();
        logic [15:0] v; logic oe;
        pi_write(2'd2, 16'h0011);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || txn !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: req=%b txn=%b want 0 0", bus_req, txn);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pi_read(2'd3, v, oe);
        n_checks++;
        if (v !== 16'h0002) begin
            n_fail++;
            $display("FAIL rst_mid_status: got %h want 0002", v);
        end
    endtask

    task automatic test_random();
        logic [15:0] v, d; logic oe;
        logic [1:0] a;
        int op;
        for (int i = 0; i < 40; i++) begin
            ipl = 3'($urandom_range(0, 7));
            op = $urandom_range(0, 5);
            d = 16'($urandom);
            if (op < 4) pi_write(2'(op), d);
            else bus_pulse(1'b1, op == 5, d);
            for (int r = 0; r < 4; r++) begin
                a = 2'(r);
                pi_read(a, v, oe);
                n_checks++;
                if (v !== model_read(a)) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d] reg%0d: got %h want %h", i, r, v, model_read(a));
                end
            end
            n_checks++;
            if (bus_req !== m_busy || txn !== m_busy || reset_out !== m_ro) begin
                n_fail++;
                $display("FAIL rand_outs[%0d]: req=%b txn=%b ro=%b want %b %b %b",
                         i, bus_req, txn, reset_out, m_busy, m_busy, m_ro);
            end
            if (m_busy) begin
                n_checks++;
                if (bus_addr !== m_addr || bus_sz !== m_sz || bus_rw !== m_rw || bus_dout !== m_wdata) begin
                    n_fail++;
                    $display("FAIL rand_bus[%0d]: addr=%h sz=%b rw=%b dout=%h want %h %b %b %h",
                             i, bus_addr, bus_sz, bus_rw, bus_dout, m_addr, m_sz, m_rw, m_wdata);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_word_read();
        test_byte_write();
        test_overrun();
        test_abort();
        test_status_ipl();
        test_collision();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
